// File: rtl/bram_window_fetcher.sv
// rtl/bram_window_fetcher.sv - raster-order 3x3 edge-clamped window fetcher reading a 1-cycle-latency BRAM
module bram_window_fetcher #(
    parameter int ADDR_WIDTH = 18,
    parameter int BIT_WIDTH  = 8,
    parameter int IMG_W      = 512,
    parameter int IMG_H      = 512
) (
    input  logic                       clka,
    input  logic                       rsta,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       bram_en,
    output logic [ADDR_WIDTH-1:0]      bram_addr,
    input  logic [BIT_WIDTH-1:0]       bram_dout,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [9*BIT_WIDTH-1:0]     win_data,
    output logic [$clog2(IMG_W)-1:0]   win_x,
    output logic [$clog2(IMG_H)-1:0]   win_y
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_ONE = XW'(1);
    localparam logic [YW-1:0] Y_ONE = YW'(1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(IMG_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [3:0]      k_q;
    logic [1:0]      kx_q, ky_q;
    logic [XW-1:0]   cx;
    logic [YW-1:0]   cy;
    logic            last_pix;

    assign last_pix = (x_q == X_MAX) && (y_q == Y_MAX);
    assign win_x    = x_q;
    assign win_y    = y_q;

    // Neighbour offset (kx,ky) in {0,1,2} maps to {-1,0,+1}, clamped at the image border.
    always_comb begin
        cx = x_q;
        cy = y_q;
        if (kx_q == 2'd0 && x_q != '0) begin
            cx = x_q - X_ONE;
        end else if (kx_q == 2'd2 && x_q != X_MAX) begin
            cx = x_q + X_ONE;
        end
        if (ky_q == 2'd0 && y_q != '0) begin
            cy = y_q - Y_ONE;
        end else if (ky_q == 2'd2 && y_q != Y_MAX) begin
            cy = y_q + Y_ONE;
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        bram_en   = 1'b0;
        bram_addr = '0;
        win_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                busy      = 1'b1;
                bram_en   = 1'b1;
                bram_addr = ADDR_WIDTH'(cy) * ROW_STRIDE + ADDR_WIDTH'(cx);
                if (k_q == 4'd8) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy    = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                busy      = 1'b1;
                win_valid = 1'b1;
                if (win_ready) state_d = last_pix ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read data lags its address by one cycle, so FETCH slot k lands while slot k+1 is issued.
    always_ff @(posedge clka) begin
        if (rsta) begin
            x_q      <= '0;
            y_q      <= '0;
            k_q      <= '0;
            kx_q     <= '0;
            ky_q     <= '0;
            win_data <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_q  <= '0;
                        y_q  <= '0;
                        k_q  <= '0;
                        kx_q <= '0;
                        ky_q <= '0;
                    end
                end
                S_FETCH: begin
                    if (k_q != 4'd0) begin
                        win_data[(int'(k_q) - 1) * BIT_WIDTH +: BIT_WIDTH] <= bram_dout;
                    end
                    k_q <= k_q + 4'd1;
                    if (kx_q == 2'd2) begin
                        kx_q <= 2'd0;
                        ky_q <= ky_q + 2'd1;
                    end else begin
                        kx_q <= kx_q + 2'd1;
                    end
                end
                S_DRAIN: begin
                    win_data[8 * BIT_WIDTH +: BIT_WIDTH] <= bram_dout;
                end
                S_OUT: begin
                    if (win_ready) begin
                        k_q  <= '0;
                        kx_q <= '0;
                        ky_q <= '0;
                        if (!last_pix) begin
                            if (x_q == X_MAX) begin
                                x_q <= '0;
                                y_q <= y_q + Y_ONE;
                            end else begin
                                x_q <= x_q + X_ONE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
